// File: rtl/div_iter_unit.sv
// ============================================================================
// div_iter_unit : multi-cycle restoring divider for DIV/DIVU in execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

module div_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic                 annul_i,
   input  logic                 hold_i,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   div_q;
   logic               neg_quo_q;
   logic               neg_rem_q;

   logic               accept_d;
   logic [WIDTH-1:0]   a_mag_d;
   logic [WIDTH-1:0]   b_mag_d;
   logic [WIDTH+1:0]   rem_shift_d;
   logic [WIDTH+1:0]   diff_d;
   logic               qbit_d;
   logic [WIDTH:0]     rem_step_d;
   logic [WIDTH-1:0]   quo_step_d;
   logic [WIDTH-1:0]   quo_fin_d;
   logic [WIDTH-1:0]   rem_fin_d;

   assign accept_d = (state_q == S_IDLE) && start_i && !annul_i;
   assign ready_o  = !((state_q == S_BUSY) || accept_d);

   assign a_mag_d = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag_d = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

   // Dividend bits are consumed from the top of the quotient shift register
   // while quotient bits enter at the bottom.
   assign rem_shift_d = {rem_q, quo_q[WIDTH-1]};
   assign diff_d      = rem_shift_d - {2'b00, div_q};
   assign qbit_d      = !diff_d[WIDTH+1];
   assign rem_step_d  = qbit_d ? diff_d[WIDTH:0] : rem_shift_d[WIDTH:0];
   assign quo_step_d  = {quo_q[WIDTH-2:0], qbit_d};

   assign quo_fin_d = neg_quo_q ? -quo_step_d : quo_step_d;
   assign rem_fin_d = neg_rem_q ? -rem_step_d[WIDTH-1:0] : rem_step_d[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_o  <= '0;
      end else if (annul_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  rem_q     <= '0;
                  quo_q     <= a_mag_d;
                  div_q     <= b_mag_d;
                  neg_quo_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  neg_rem_q <= signed_i && a_i[WIDTH-1];
                  cnt_q     <= '0;
                  state_q   <= S_BUSY;
               end
            end
            S_BUSY: begin
               rem_q <= rem_step_d;
               quo_q <= quo_step_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  result_o <= {rem_fin_d, quo_fin_d};
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               // start_i still belongs to the finished instruction here.
               if (!hold_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
// ============================================================================
// tb_div_iter_unit : directed and random checks of div_iter_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_iter_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        annul_i;
   logic        hold_i;
   logic        ready_o;
   logic [63:0] result_o;

   int errors = 0;
   int checks = 0;

   div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .signed_i (signed_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .annul_i  (annul_i),
      .hold_i   (hold_i),
      .ready_o  (ready_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, truncating division.
   function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         if (sg) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
         return {a, 32'hFFFF_FFFF};
      end
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic run_div(input string tag, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int hold_n);
      int n;
      @(negedge clk);
      start_i  = 1'b1;
      signed_i = sg;
      a_i      = a;
      b_i      = b;
      annul_i  = 1'b0;
      hold_i   = (hold_n > 0);
      n = 0;
      #1;
      while (!ready_o && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check({tag, "_stall"}, 64'(n), 64'd33);
      check({tag, "_result"}, result_o, exp);
      if (hold_n > 0) begin
         for (int i = 1; i < hold_n; i++) begin
            @(negedge clk);
            #1;
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_result"}, result_o, exp);
         end
         @(negedge clk);
         hold_i = 1'b0;
         #1;
         check({tag, "_release_ready"}, 64'(ready_o), 64'd1);
         @(negedge clk);
         start_i = 1'b0;
         #1;
         check({tag, "_idle_ready"}, 64'(ready_o), 64'd1);
         @(negedge clk);
         #1;
         check({tag, "_norestart_ready"}, 64'(ready_o), 64'd1);
         check({tag, "_norestart_result"}, result_o, exp);
      end
   endtask

   initial begin
      logic [63:0] prev;
      bit          sg;
      logic [31:0] ra, rb;

      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
      annul_i = 1'b0; hold_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_ready", 64'(ready_o), 64'd1);
      check("reset_result", result_o, 64'd0);

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0);
      run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, 0);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
      run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 0);
      run_div("hold", 1'b0, 32'd1000, 32'd9, 64'h0000_0001_0000_006F, 10);

      // Annul in the middle of a division.
      prev = result_o;
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; a_i = 32'd77; b_i = 32'd5;
      repeat (12) @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      #1;
      check("annul_busy_ready", 64'(ready_o), 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      #1;
      check("annul_ready", 64'(ready_o), 64'd1);
      check("annul_result", result_o, prev);
      @(negedge clk);
      #1;
      check("annul_idle_ready", 64'(ready_o), 64'd1);

      // Annul alongside start in IDLE blocks the accept.
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1;
      #1;
      check("annul_start_ready", 64'(ready_o), 64'd1);
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      #1;
      check("annul_noaccept_ready", 64'(ready_o), 64'd1);

      // Reset in the middle of a division.
      @(negedge clk);
      start_i = 1'b1; a_i = 32'd123; b_i = 32'd4;
      repeat (20) @(negedge clk);
      rst = 1'b1; start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_ready", 64'(ready_o), 64'd1);
      check("midrst_result", result_o, 64'd0);

      run_div("b2b_9_2", 1'b0, 32'd9, 32'd2, 64'h0000_0001_0000_0004, 0);
      run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 0);

      for (int i = 0; i < 10; i++) begin
         sg = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         if (i == 4) rb = 32'd0;
         if (i == 7) rb = 32'hFFFF_FFFF;
         run_div("random", sg, ra, rb, ref_div(sg, ra, rb), (i == 5) ? 3 : 0);
      end

      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
